// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier load/unload blocks.
// Element geometry and the result-collector state encoding.
package mm_pkg;

  localparam int ELEM_W         = 18;
  localparam int N_ELEM         = 9;
  localparam int BYTES_PER_ELEM = 3;
  localparam int IDX_W          = 4;
  localparam int BYTE_IDX_W     = 2;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } coll_state_e;

  // Third byte carries only 2 payload bits; the rest must be zero.
  function automatic logic pad_bad(input logic [7:0] b);
    return |b[7:2];
  endfunction

endpackage

// File: rtl/mm_byte_assembler.sv
// Rebuilds 18-bit elements from a 3-byte, LSB-first byte stream.
// Emits a one-cycle word_valid on the cycle the third byte arrives.
module mm_byte_assembler
  import mm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output elem_t      word_o,
  output logic       word_valid_o,
  output logic       pad_err_o
);

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [15:0]           low_q, low_d;
  logic                  last;

  assign last = byte_idx_q == BYTE_IDX_W'(BYTES_PER_ELEM - 1);

  always_comb begin
    byte_idx_d = byte_idx_q;
    low_d      = low_q;
    if (clr_i) begin
      byte_idx_d = '0;
      low_d      = '0;
    end else if (en_i) begin
      unique case (1'b1)
        (byte_idx_q == 2'd0): begin
          low_d[7:0] = byte_i;
          byte_idx_d = 2'd1;
        end
        (byte_idx_q == 2'd1): begin
          low_d[15:8] = byte_i;
          byte_idx_d  = 2'd2;
        end
        default: byte_idx_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      low_q      <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      low_q      <= low_d;
    end
  end

  assign word_valid_o = en_i & ~clr_i & last;
  assign word_o       = {byte_i[1:0], low_q};
  assign pad_err_o    = word_valid_o & pad_bad(byte_i);

endmodule

// File: rtl/mm_result_collector.sv
// Collects the nine 18-bit products of a 3x3 multiply from the byte
// stream and serves them through a registered random-access read port.
module mm_result_collector
  import mm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [ELEM_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             fmt_err,
  output logic             overflow
);

  coll_state_e      state_q, state_d;
  logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
  elem_t            mem_q [N_ELEM];
  elem_t            mem_d [N_ELEM];
  elem_t            rd_data_q, rd_data_d;
  logic             fmt_q, fmt_d;
  logic             ovf_q, ovf_d;

  logic  accept;
  logic  word_valid;
  logic  pad_err;
  elem_t word;
  logic  last_elem;

  // start wins over a coincident byte, so that byte never reaches the assembler
  assign accept    = rx_valid & (state_q == ST_COLLECT) & ~start;
  assign last_elem = elem_idx_q == IDX_W'(N_ELEM - 1);

  mm_byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start),
    .en_i         (accept),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid),
    .pad_err_o    (pad_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      unique case (1'b1)
        (state_q == ST_COLLECT):
          if (word_valid && last_elem) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = state_q == ST_COLLECT;
    done = state_q == ST_DONE;
  end

  always_comb begin
    elem_idx_d = elem_idx_q;
    fmt_d      = fmt_q | pad_err;
    ovf_d      = ovf_q | (rx_valid & (state_q == ST_DONE));
    for (int i = 0; i < N_ELEM; i++) begin
      mem_d[i] = mem_q[i];
      if (word_valid && elem_idx_q == IDX_W'(i)) mem_d[i] = word;
    end
    if (word_valid) elem_idx_d = elem_idx_q + 1'b1;
    if (start) begin
      elem_idx_d = '0;
      fmt_d      = 1'b0;
      ovf_d      = 1'b0;
      for (int i = 0; i < N_ELEM; i++) mem_d[i] = '0;
    end
  end

  // Indices 9..15 fall through every compare and read back as zero
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data_d = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_idx_q <= '0;
      fmt_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < N_ELEM; i++) mem_q[i] <= '0;
    end else begin
      elem_idx_q <= elem_idx_d;
      fmt_q      <= fmt_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < N_ELEM; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign fmt_err  = fmt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Scoreboard bench: the driver queues the value expected after each edge,
// a monitor pops and compares on the following falling edge.
module tb_mm_result_collector;
  import mm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic [17:0] rd_data;
  logic        busy, done, fmt_err, overflow;

  mm_result_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .fmt_err  (fmt_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [17:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          nreq = 0;
  int          pend = 0;
  int          checks = 0;
  int          failures = 0;
  logic [17:0] mat [9];

  always @(posedge clk) pend <= nreq;

  always @(negedge clk) begin
    for (int k = 0; k < pend; k++) begin
      exp_t e;
      logic [17:0] act;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: no expectation queued");
      end else begin
        e = sb.pop_front();
        act = e.is_rd ? rd_data : {14'd0, busy, done, fmt_err, overflow};
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  function automatic void exp_rd(string nm, logic [17:0] v);
    sb.push_back('{1'b1, v, nm});
    nreq++;
  endfunction

  // status word {busy, done, fmt_err, overflow}
  function automatic void exp_st(string nm, logic [3:0] v);
    sb.push_back('{1'b0, {14'd0, v}, nm});
    nreq++;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    nreq     = 0;
  endtask

  function automatic logic [7:0] sbyte(int e, int b, bit bad4);
    logic [7:0] r;
    r = 8'h00;
    if (e == 0) r = (b == 2) ? 8'h03 : 8'hFF;
    else if (e == 8) r = (b == 0) ? 8'h45 : (b == 1) ? 8'h23 : 8'h01;
    else if (b == 0) r = 8'(e);
    if (bad4 && e == 4 && b == 2) r = 8'h87;
    return r;
  endfunction

  task automatic send(int n, bit gap, bit bad4);
    for (int k = 0; k < n; k++) begin
      rx_valid = 1'b1;
      rx_data  = sbyte(k / 3, k % 3, bad4);
      if (n == 27 && k == 25) exp_st("busy_before_last", {2'b10, bad4, 1'b0});
      if (n == 27 && k == 26) exp_st("done_after_last", {2'b01, bad4, 1'b0});
      tick();
      if (gap) tick();
    end
  endtask

  task automatic read_all(string nm);
    for (int i = 0; i < 9; i++) begin
      rd_idx = 4'(i);
      exp_rd($sformatf("%s_C%0d", nm, i), mat[i]);
      tick();
    end
  endtask

  task automatic read_oob();
    for (int i = 9; i < 16; i++) begin
      rd_idx = 4'(i);
      exp_rd($sformatf("oob_idx%0d", i), 18'h0);
      tick();
    end
  endtask

  task automatic do_start(bit with_byte);
    start    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hAA;
    exp_st("start_busy", 4'b1000);
    tick();
  endtask

  task automatic set_good();
    mat[0] = 18'h3FFFF;
    for (int i = 1; i < 8; i++) mat[i] = 18'(i);
    mat[8] = 18'h12345;
  endtask

  task automatic set_zero();
    for (int i = 0; i < 9; i++) mat[i] = 18'h0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rd_idx = 4'd0;
    exp_st("reset_status", 4'b0000);
    exp_rd("reset_rd", 18'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // bytes in IDLE are ignored
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    exp_st("idle_ignore", 4'b0000);
    tick();

    // back-to-back stream
    do_start(1'b0);
    send(27, 1'b0, 1'b0);
    exp_st("done_hold", 4'b0100);
    tick();
    set_good();
    read_all("b2b");

    // gapped stream
    do_start(1'b0);
    send(27, 1'b1, 1'b0);
    read_all("gap");

    // bad padding on element 4
    do_start(1'b0);
    send(27, 1'b0, 1'b1);
    set_good();
    mat[4] = 18'h30004;
    read_all("fmt");

    // overflow after done
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    exp_st("ovf_1", 4'b0111);
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    exp_st("ovf_2", 4'b0111);
    tick();
    read_all("ovf");

    // start clears everything
    do_start(1'b0);
    set_zero();
    read_all("clr");

    // restart mid-collection with a coincident byte
    send(13, 1'b0, 1'b0);
    rd_idx = 4'd0;
    exp_rd("mid_C0", 18'h3FFFF);
    tick();
    rd_idx = 4'd3;
    exp_rd("mid_C3", 18'h3);
    tick();
    rd_idx = 4'd4;
    exp_rd("mid_C4", 18'h0);
    tick();
    do_start(1'b1);
    send(27, 1'b0, 1'b0);
    set_good();
    read_all("restart");

    // reset mid-collection
    do_start(1'b0);
    send(20, 1'b0, 1'b0);
    rst_n  = 1'b0;
    rd_idx = 4'd0;
    exp_st("rst_status", 4'b0000);
    exp_rd("rst_C0", 18'h0);
    tick();
    rst_n = 1'b1;
    send(3, 1'b0, 1'b0);
    exp_st("post_rst_idle", 4'b0000);
    tick();
    set_zero();
    read_all("post_rst");
    read_oob();

    do_start(1'b0);
    send(27, 1'b0, 1'b0);
    set_good();
    read_all("final");
    read_oob();

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_result_collector.md
# mm_result_collector

Receive-side counterpart of the matrix-multiplier result stream. Captures the byte stream of the nine 18-bit products of a 3x3 matrix multiply (byte plus valid strobe), reassembles each element, stores all nine, and exposes them through a registered random-access read port. Sits on the host/test side of the multiplier's output pins and completes the load → compute → unload loop.

## Interface
- ELEM_W, 18, result element width in bits
- N_ELEM, 9, elements per result matrix (row-major C0..C8)
- BYTES_PER_ELEM, 3, bytes per element on the wire, LSB byte first
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; arms the collector and clears results and flags
- rx_data  in  8  result byte from the multiplier's uo_out
- rx_valid  in  1  byte strobe from the multiplier's uio_out[0]; one byte per cycle it is high
- rd_idx  in  4  element index to read, 0..8
- rd_data  out  18  registered read data for rd_idx
- busy  out  1  high in COLLECT
- done  out  1  high in DONE; all nine elements valid
- fmt_err  out  1  sticky; a third byte of an element had a nonzero bit in [7:2]
- overflow  out  1  sticky; rx_valid seen while in DONE

## Operation
- States: IDLE, COLLECT, DONE. Reset → IDLE.
- IDLE: rx_valid ignored. start → COLLECT.
- COLLECT: each rx_valid cycle accepts rx_data into byte slot byte_idx (0,1,2) of the assembly register. On slot 2: element = {rx_data[1:0], byte1, byte0} written to C[elem_idx]; rx_data[7:2] ≠ 0 sets fmt_err (element still stored, padding bits dropped); byte_idx → 0, elem_idx +1. After element 8 is written → DONE.
- Gaps (rx_valid low) between any bytes are legal; counters hold.
- DONE: results held. rx_valid sets overflow; byte discarded.
- start in any state (including mid-COLLECT): → COLLECT, byte_idx=elem_idx=0, all C[i]=0, fmt_err=overflow=0. start has priority over a simultaneous rx_valid; that byte is dropped.
- Read: rd_data <= (rd_idx < 9) ? C[rd_idx] : 0, every cycle, any state. Reads of elements not yet written return 0.
- Reset mid-operation: all state, counters, storage, flags to 0 immediately.

## Timing
- Reset values: rd_data=0, busy=0, done=0, fmt_err=0, overflow=0; C[0..8]=0.
- busy rises the cycle after start is sampled.
- Element write occurs on the edge sampling its third byte; readable via rd_data one edge later (rd_idx applied, data valid after next edge: 1-cycle read latency).
- done rises the cycle after the edge sampling the 27th accepted byte; busy falls the same cycle.
- fmt_err/overflow assert the cycle after the offending byte is sampled.
- Minimum collection time: 27 cycles of back-to-back rx_valid.

## Structure
- Package mm_pkg: ELEM_W, N_ELEM, BYTES_PER_ELEM, element index width, collector state enum (IDLE/COLLECT/DONE); shared with the load-side blocks.
- Sub-module mm_byte_assembler: byte_idx counter, 16-bit low-byte holding register, outputs 18-bit word, word_valid pulse, pad_err; cleared by start/reset. Top holds FSM, elem_idx, storage array, read mux, flags.

## Test plan
- Back-to-back 27 bytes, C0 = FF FF 03, C8 = 45 23 01, others i 00 00 → done after 27th byte; rd_idx 0 → 0x3FFFF, 8 → 0x12345, 3 → 0x00003; fmt_err=0.
- Same stream with rx_valid low every other cycle → identical contents; done 1 cycle after last byte.
- Element 4 third byte = 0x87 → fmt_err=1, C4 stored as {2'b11, b1, b0}; collection still completes.
- Two extra bytes after done → overflow=1, C unchanged; start clears overflow, busy=1, all rd_data=0.
- start asserted after 13 bytes (with simultaneous rx_valid) → byte dropped, counters reset; fresh 27-byte stream produces correct matrix.
- rst_n low for 1 cycle after 20 bytes → all outputs 0, IDLE; bytes ignored until start; rd_idx 9..15 always → 0.
